// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - framed UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits
// Accepts a payload when ready, serialises it from a registered line driver, pulses done at frame end.
module uart_tx_framed #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 2);

  generate
    if ((CLKS_PER_BIT < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
        (PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_param
      $error("uart_tx_framed: parameter outside legal range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_tx;
  logic                   r_rdy_en;
  logic                   w_bit_end;
  logic                   w_last_stop;
  logic                   w_ready;
  logic                   w_accept;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bit_end    = (r_cnt == CNT_LAST);
    w_last_stop  = (r_state == S_STOP) && w_bit_end && (r_bit_idx == STOP_LAST);
    w_ready      = r_rdy_en && ((r_state == S_IDLE) || w_last_stop);
    w_accept     = i_valid && w_ready;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_START;
      S_START:  if (w_bit_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bit_idx == DATA_LAST)) begin
          w_state_next = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
      S_STOP:   if (w_last_stop) w_state_next = w_accept ? S_START : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // r_tx is loaded with the value of the upcoming bit at each boundary so the line is a pure flop.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rdy_en  <= 1'b0;
      r_tx      <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_shift   <= i_data;
        r_par     <= (^i_data) ^ PAR_ODD;
        r_tx      <= 1'b0;
        r_cnt     <= '0;
        r_bit_idx <= '0;
      end else if (r_state != S_IDLE) begin
        if (!w_bit_end) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
          case (r_state)
            S_START: begin
              r_tx      <= r_shift[0];
              r_bit_idx <= '0;
            end
            S_DATA: begin
              if (r_bit_idx == DATA_LAST) begin
                r_bit_idx <= '0;
                r_tx      <= PAR_EN ? r_par : 1'b1;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                r_tx      <= r_shift[1];
              end
            end
            S_PARITY: begin
              r_tx      <= 1'b1;
              r_bit_idx <= '0;
            end
            S_STOP: begin
              r_tx      <= 1'b1;
              r_bit_idx <= (r_bit_idx == STOP_LAST) ? '0 : r_bit_idx + 1'b1;
            end
            default: r_tx <= 1'b1;
          endcase
        end
      end
    end
  end

  assign o_tx    = r_tx;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = w_last_stop;
  assign o_ready = w_ready;

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb/tb_uart_tx_framed.sv - directed self-checking bench for uart_tx_framed
// Four instances cover even/odd/no parity, two stop bits and the CLKS_PER_BIT/DATA_BITS extremes.
module tb_uart_tx_framed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [7:0] a_data;  logic a_valid; logic a_ready, a_tx, a_busy, a_done;
  logic [7:0] b_data;  logic b_valid; logic b_ready, b_tx, b_busy, b_done;
  logic [6:0] c_data;  logic c_valid; logic c_ready, c_tx, c_busy, c_done;
  logic [8:0] d_data;  logic d_valid; logic d_ready, d_tx, d_busy, d_done;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_a (
    .clk(clk), .i_reset_n(rst_n), .i_data(a_data), .i_valid(a_valid),
    .o_ready(a_ready), .o_tx(a_tx), .o_busy(a_busy), .o_done(a_done));

  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .i_reset_n(rst_n), .i_data(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy), .o_done(b_done));

  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .i_reset_n(rst_n), .i_data(c_data), .i_valid(c_valid),
    .o_ready(c_ready), .o_tx(c_tx), .o_busy(c_busy), .o_done(c_done));

  uart_tx_framed #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_d (
    .clk(clk), .i_reset_n(rst_n), .i_data(d_data), .i_valid(d_valid),
    .o_ready(d_ready), .o_tx(d_tx), .o_busy(d_busy), .o_done(d_done));

  task automatic test_reset();
    logic [15:0] got;
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
    a_data = '0; b_data = '0; c_data = '0; d_data = '0;
    repeat (2) @(negedge clk);
    got = {a_tx, a_done, a_busy, a_ready, b_tx, b_done, b_busy, b_ready,
           c_tx, c_done, c_busy, c_ready, d_tx, d_done, d_busy, d_ready};
    n_total++;
    if (got !== 16'b1000_1000_1000_1000) $display("FAIL reset_state got %b want %b", got, 16'b1000_1000_1000_1000);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (a_ready !== 1'b0) $display("FAIL reset_ready_before_edge got %b want 0", a_ready);
    else n_pass++;
    @(negedge clk);
    got = {12'd0, a_ready, b_ready, c_ready, d_ready};
    n_total++;
    if (got !== 16'h000F) $display("FAIL reset_ready_after_edge got %b want %b", got, 16'h000F);
    else n_pass++;
  endtask

  task automatic test_parity_even();
    logic [10:0] frame;
    logic [3:0]  exp;
    frame = 11'b1_0_10100101_0;
    @(negedge clk); a_data = 8'hA5; a_valid = 1'b1;
    @(posedge clk); #1; a_valid = 1'b0; a_data = 8'hFF;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      exp = {(k <= 44) ? frame[(k-1)/4] : 1'b1, k == 44, k <= 44, k >= 44};
      n_total++;
      if ({a_tx, a_done, a_busy, a_ready} !== exp)
        $display("FAIL parity_even k=%0d tx/done/busy/ready got %b want %b", k, {a_tx, a_done, a_busy, a_ready}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] f1, f2;
    logic [3:0]  exp;
    logic        bit_e;
    f1 = 11'b1_1_00000000_0;
    f2 = 11'b1_1_11111111_0;
    @(negedge clk); b_data = 8'h00; b_valid = 1'b1;
    @(posedge clk); #1; b_data = 8'hFF;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k <= 44)      bit_e = f1[(k-1)/4];
      else if (k <= 88) bit_e = f2[(k-45)/4];
      else              bit_e = 1'b1;
      exp = {bit_e, (k == 44) || (k == 88), k <= 88, (k == 44) || (k >= 88)};
      n_total++;
      if ({b_tx, b_done, b_busy, b_ready} !== exp)
        $display("FAIL back_to_back k=%0d tx/done/busy/ready got %b want %b", k, {b_tx, b_done, b_busy, b_ready}, exp);
      else n_pass++;
      if (k == 45) b_valid = 1'b0;
    end
  endtask

  task automatic test_two_stop();
    logic [9:0] frame;
    logic [3:0] exp;
    frame = 10'b11_1010101_0;
    @(negedge clk); c_data = 7'h55; c_valid = 1'b1;
    @(posedge clk); #1; c_valid = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      exp = {(k <= 40) ? frame[(k-1)/4] : 1'b1, k == 40, k <= 40, k >= 40};
      n_total++;
      if ({c_tx, c_done, c_busy, c_ready} !== exp)
        $display("FAIL two_stop k=%0d tx/done/busy/ready got %b want %b", k, {c_tx, c_done, c_busy, c_ready}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_busy_request();
    logic [10:0] f1, f2;
    logic [3:0]  exp;
    logic        bit_e;
    f1 = 11'b1_0_00010010_0;
    f2 = 11'b1_0_10011001_0;
    @(negedge clk); a_data = 8'h12; a_valid = 1'b1;
    @(posedge clk); #1; a_valid = 1'b0;
    for (int k = 1; k <= 92; k++) begin
      @(negedge clk);
      if (k <= 44)      bit_e = f1[(k-1)/4];
      else if (k <= 88) bit_e = f2[(k-45)/4];
      else              bit_e = 1'b1;
      exp = {bit_e, (k == 44) || (k == 88), k <= 88, (k == 44) || (k >= 88)};
      n_total++;
      if ({a_tx, a_done, a_busy, a_ready} !== exp)
        $display("FAIL busy_request k=%0d tx/done/busy/ready got %b want %b", k, {a_tx, a_done, a_busy, a_ready}, exp);
      else n_pass++;
      if (k == 10) begin a_valid = 1'b1; a_data = 8'h99; end
      if (k == 11) a_valid = 1'b0;
      if (k == 20) a_valid = 1'b1;
      if (k == 45) a_valid = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    logic [10:0] f1, f2;
    logic [3:0]  exp;
    f1 = 11'b1_0_11110000_0;
    f2 = 11'b1_0_00111100_0;
    @(negedge clk); a_data = 8'hF0; a_valid = 1'b1;
    @(posedge clk); #1; a_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      n_total++;
      if ({a_tx, a_busy} !== {f1[(k-1)/4], 1'b1})
        $display("FAIL abort_prefix k=%0d tx/busy got %b want %b", k, {a_tx, a_busy}, {f1[(k-1)/4], 1'b1});
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({a_tx, a_done, a_busy, a_ready} !== 4'b1000)
      $display("FAIL abort_async got %b want 1000", {a_tx, a_done, a_busy, a_ready});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if ({a_tx, a_done, a_busy, a_ready} !== 4'b1000)
        $display("FAIL abort_held k=%0d got %b want 1000", k, {a_tx, a_done, a_busy, a_ready});
      else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    a_data = 8'h3C; a_valid = 1'b1;
    @(posedge clk); #1; a_valid = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      exp = {(k <= 44) ? f2[(k-1)/4] : 1'b1, k == 44, k <= 44, k >= 44};
      n_total++;
      if ({a_tx, a_done, a_busy, a_ready} !== exp)
        $display("FAIL abort_fresh k=%0d tx/done/busy/ready got %b want %b", k, {a_tx, a_done, a_busy, a_ready}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_wide();
    logic [8:0]  data [2];
    logic [11:0] frame [2];
    logic [3:0]  exp;
    data[0] = 9'h1A7; frame[0] = 12'b1_0_110100111_0;
    data[1] = 9'h0B3; frame[1] = 12'b1_1_010110011_0;
    for (int f = 0; f < 2; f++) begin
      @(negedge clk); d_data = data[f]; d_valid = 1'b1;
      @(posedge clk); #1; d_valid = 1'b0;
      for (int k = 1; k <= 26; k++) begin
        @(negedge clk);
        exp = {(k <= 24) ? frame[f][(k-1)/2] : 1'b1, k == 24, k <= 24, k >= 24};
        n_total++;
        if ({d_tx, d_done, d_busy, d_ready} !== exp)
          $display("FAIL wide f=%0d k=%0d tx/done/busy/ready got %b want %b", f, k, {d_tx, d_done, d_busy, d_ready}, exp);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_back_to_back();
    test_two_stop();
    test_busy_request();
    test_reset_abort();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
